// File: rtl/axil_pkg.sv
// Shared AXI4-Lite encodings and the traffic-master state machine types.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b010;

   typedef enum logic [1:0] {
      MODE_WR        = 2'd0,
      MODE_RD        = 2'd1,
      MODE_WR_RD     = 2'd2,
      MODE_WR_RD_ALT = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_RESP,
      ST_DONE
   } state_t;

endpackage

// File: rtl/axil_test_master_sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at 16'hFFFF.
module sat_counter16
   import axil_pkg::*;
(
   input  logic        ACLK,
   input  logic        reset,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] count_q;
   logic [15:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge ACLK or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/axil_test_master.sv
// AXI4-Lite traffic master: sweeps DEPTH words writing seed+idx, reading back, or both with compare.
module axil_test_master
   import axil_pkg::*;
#(
   parameter int          ADDR_WIDTH = 8,
   parameter int          DATA_WIDTH = 32,
   parameter int          DEPTH      = 8,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                    ACLK,
   input  logic                    reset,
   input  logic                    start,
   input  logic [1:0]              mode,
   input  logic [DATA_WIDTH-1:0]   seed,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             err_count,
   output logic [15:0]             mismatch_count,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic [2:0]              AWPROT,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic [2:0]              ARPROT,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RVALID,
   output logic                    RREADY
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] i);
      return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(i) * ADDR_WIDTH'(BYTES);
   endfunction

   state_t                  state_q, state_d;
   mode_t                   mode_q, mode_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   seed_q, seed_d;
   logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                    arvalid_q, arvalid_d, rready_q, rready_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic [2:0]              prot_q, prot_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic                    cnt_clr, err_inc, mis_inc;

   logic [IDX_W-1:0] idx_next;
   logic             idx_last;

   assign idx_next = idx_q + IDX_W'(1);
   assign idx_last = (idx_q == IDX_W'(DEPTH - 1));

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      idx_d     = idx_q;
      seed_d    = seed_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      prot_d    = prot_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cnt_clr   = 1'b0;
      err_inc   = 1'b0;
      mis_inc   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d  = (mode_t'(mode) == MODE_WR_RD_ALT) ? MODE_WR_RD : mode_t'(mode);
               seed_d  = seed;
               idx_d   = '0;
               cnt_clr = 1'b1;
               busy_d  = 1'b1;
               prot_d  = PROT_DEFAULT;
               wstrb_d = '1;
               if (mode_t'(mode) == MODE_RD) begin
                  state_d   = ST_RD_REQ;
                  arvalid_d = 1'b1;
                  araddr_d  = word_addr(IDX_W'(0));
               end else begin
                  state_d   = ST_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = word_addr(IDX_W'(0));
                  wdata_d   = seed;
               end
            end
         end
         // AW and W complete independently; leave once neither is still pending.
         ST_WR_REQ: begin
            if (AWREADY) awvalid_d = 1'b0;
            if (WREADY)  wvalid_d  = 1'b0;
            if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
               state_d  = ST_WR_RESP;
               bready_d = 1'b1;
            end
         end
         ST_WR_RESP: begin
            if (BVALID) begin
               bready_d = 1'b0;
               err_inc  = (BRESP != RESP_OKAY);
               if (idx_last) begin
                  if (mode_q == MODE_WR_RD) begin
                     state_d   = ST_RD_REQ;
                     idx_d     = '0;
                     arvalid_d = 1'b1;
                     araddr_d  = word_addr(IDX_W'(0));
                  end else begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  state_d   = ST_WR_REQ;
                  idx_d     = idx_next;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = word_addr(idx_next);
                  wdata_d   = seed_q + DATA_WIDTH'(idx_next);
               end
            end
         end
         ST_RD_REQ: begin
            if (ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            if (RVALID) begin
               rready_d = 1'b0;
               err_inc  = (RRESP != RESP_OKAY);
               // Data of an errored read is meaningless, so only OKAY beats are compared.
               mis_inc  = (mode_q == MODE_WR_RD) && (RRESP == RESP_OKAY) &&
                          (RDATA != seed_q + DATA_WIDTH'(idx_q));
               if (idx_last) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = ST_RD_REQ;
                  idx_d     = idx_next;
                  arvalid_d = 1'b1;
                  araddr_d  = word_addr(idx_next);
               end
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_WR;
         idx_q     <= '0;
         seed_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         prot_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         idx_q     <= idx_d;
         seed_q    <= seed_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         prot_q    <= prot_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   sat_counter16 u_err_cnt (
      .ACLK  (ACLK),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (err_inc),
      .count (err_count)
   );

   sat_counter16 u_mis_cnt (
      .ACLK  (ACLK),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (mis_inc),
      .count (mismatch_count)
   );

   assign AWADDR  = awaddr_q;
   assign AWPROT  = prot_q;
   assign AWVALID = awvalid_q;
   assign WDATA   = wdata_q;
   assign WSTRB   = wstrb_q;
   assign WVALID  = wvalid_q;
   assign BREADY  = bready_q;
   assign ARADDR  = araddr_q;
   assign ARPROT  = prot_q;
   assign ARVALID = arvalid_q;
   assign RREADY  = rready_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_axil_test_master.sv
// Directed bench: AXI4-Lite slave model with configurable stalls/errors plus a queue scoreboard.
module tb_axil_test_master;

   logic        ACLK = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic [31:0] seed;
   logic        busy, done;
   logic [15:0] err_count, mismatch_count;
   logic [7:0]  AWADDR, ARADDR;
   logic [2:0]  AWPROT, ARPROT;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;

   always #5 ACLK = ~ACLK;

   axil_test_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(8), .BASE_ADDR(0)) dut (
      .ACLK(ACLK), .reset(reset), .start(start), .mode(mode), .seed(seed),
      .busy(busy), .done(done), .err_count(err_count), .mismatch_count(mismatch_count),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
   typedef struct { logic [15:0] err; logic [15:0] mism; } done_t;

   wr_t        exp_wr[$];
   logic [7:0] exp_rd[$];
   done_t      exp_done[$];

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   // slave configuration
   int aw_delay = 0, w_delay = 0, ar_delay = 0;
   int corrupt_word = -1;
   bit err_b = 0, err_r = 0;

   // slave state
   logic [31:0] mem [64];
   int          aw_cnt, w_cnt, ar_cnt;
   bit          have_aw, have_w, have_ar, b_pend, r_pend;
   bit          aw_wait, w_wait, ar_wait, prev_done;
   logic [7:0]  cap_awaddr, cap_araddr, aw_hold, ar_hold;
   logic [31:0] cap_wdata, w_hold, rd_word;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   always @(negedge ACLK) begin
      if (reset) begin
         AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
         BRESP = 0; RRESP = 0; RDATA = 0;
         aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
         have_aw = 0; have_w = 0; have_ar = 0; b_pend = 0; r_pend = 0;
         aw_wait = 0; w_wait = 0; ar_wait = 0; prev_done = 0;
      end else begin
         // a VALID left waiting must persist with unchanged payload
         if (aw_wait) chk("aw_hold", {AWVALID, AWADDR}, {1'b1, aw_hold});
         if (w_wait)  chk("w_hold",  {WVALID, WDATA},   {1'b1, w_hold});
         if (ar_wait) chk("ar_hold", {ARVALID, ARADDR}, {1'b1, ar_hold});

         if (b_pend) begin BVALID = 0; b_pend = 0; end
         if (r_pend) begin RVALID = 0; r_pend = 0; end

         if (!BVALID && have_aw && have_w) begin
            $display("WR addr=%h data=%h", cap_awaddr, cap_wdata);
            chk("wr_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
               wr_t e;
               e = exp_wr.pop_front();
               chk("awaddr", cap_awaddr, e.addr);
               chk("wdata", cap_wdata, e.data);
            end
            mem[cap_awaddr[7:2]] = cap_wdata;
            BVALID = 1; BRESP = err_b ? 2'b10 : 2'b00;
            have_aw = 0; have_w = 0;
         end
         if (!RVALID && have_ar) begin
            rd_word = mem[cap_araddr[7:2]];
            if (corrupt_word == int'(cap_araddr[7:2])) rd_word = rd_word ^ 32'h0000_0100;
            if (err_r) rd_word = 32'hDEAD_BEEF;
            RVALID = 1; RDATA = rd_word; RRESP = err_r ? 2'b10 : 2'b00;
            have_ar = 0;
         end

         aw_cnt = AWVALID ? aw_cnt + 1 : 0;
         w_cnt  = WVALID  ? w_cnt + 1  : 0;
         ar_cnt = ARVALID ? ar_cnt + 1 : 0;
         AWREADY = AWVALID && (aw_cnt > aw_delay);
         WREADY  = WVALID  && (w_cnt > w_delay);
         ARREADY = ARVALID && (ar_cnt > ar_delay);

         aw_wait = AWVALID && !AWREADY; aw_hold = AWADDR;
         w_wait  = WVALID && !WREADY;   w_hold  = WDATA;
         ar_wait = ARVALID && !ARREADY; ar_hold = ARADDR;

         if (AWVALID && AWREADY) begin
            chk("aw_single", have_aw, 0);
            chk("awprot", AWPROT, 3'b010);
            have_aw = 1; cap_awaddr = AWADDR;
         end
         if (WVALID && WREADY) begin
            chk("w_single", have_w, 0);
            chk("wstrb", WSTRB, 4'hF);
            have_w = 1; cap_wdata = WDATA;
         end
         if (ARVALID && ARREADY) begin
            $display("RD addr=%h", ARADDR);
            chk("rd_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) chk("araddr", ARADDR, exp_rd.pop_front());
            chk("arprot", ARPROT, 3'b010);
            have_ar = 1; cap_araddr = ARADDR;
         end
         b_pend = BVALID && BREADY;
         r_pend = RVALID && RREADY;

         if (prev_done) chk("done_pulse_busy_fall", {done, busy}, 2'b00);
         if (done) begin
            $display("DONE err=%0d mism=%0d", err_count, mismatch_count);
            chk("done_expected", exp_done.size() > 0, 1);
            chk("busy_at_done", busy, 1);
            if (exp_done.size() > 0) begin
               done_t d;
               d = exp_done.pop_front();
               chk("err_count", err_count, d.err);
               chk("mismatch_count", mismatch_count, d.mism);
            end
            done_cnt++;
         end
         prev_done = done;
      end
   end

   task automatic expect_sweep(input logic [1:0] m, input logic [31:0] s,
                               input logic [15:0] e, input logic [15:0] mm);
      done_t d;
      if (m != 2'd1)
         for (int i = 0; i < 8; i++) exp_wr.push_back('{addr: 8'(i * 4), data: s + 32'(i)});
      if (m != 2'd0)
         for (int i = 0; i < 8; i++) exp_rd.push_back(8'(i * 4));
      d.err = e; d.mism = mm;
      exp_done.push_back(d);
   endtask

   task automatic issue_start(input logic [1:0] m, input logic [31:0] s);
      @(negedge ACLK);
      mode = m; seed = s; start = 1;
      @(negedge ACLK);
      start = 0;
      chk("busy_rise", busy, 1);
      chk("first_valid", (m == 2'd1) ? {AWVALID, WVALID, ARVALID} : {AWVALID, WVALID, ARVALID},
          (m == 2'd1) ? 3'b001 : 3'b110);
   endtask

   task automatic run_sweep(input logic [1:0] m, input logic [31:0] s,
                            input logic [15:0] e, input logic [15:0] mm, input bit restart);
      int base;
      base = done_cnt;
      expect_sweep(m, s, e, mm);
      issue_start(m, s);
      if (restart) begin
         // a start during busy must be ignored entirely
         repeat (2) @(negedge ACLK);
         mode = 2'd1; seed = 32'hDEAD_0000; start = 1;
         @(negedge ACLK);
         start = 0;
      end
      for (int i = 0; i < 1000 && done_cnt == base; i++) @(negedge ACLK);
      chk("done_seen", done_cnt > base, 1);
      repeat (4) @(negedge ACLK);
      chk("idle_after_done", {busy, done, AWVALID, WVALID, ARVALID}, 0);
      chk("wr_left", exp_wr.size(), 0);
      chk("rd_left", exp_rd.size(), 0);
      chk("done_left", exp_done.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      reset = 1; start = 0; mode = 0; seed = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      repeat (3) @(negedge ACLK);
      chk("rst_ctrl", {AWVALID, WVALID, ARVALID, BREADY, RREADY, busy, done}, 0);
      chk("rst_counts", {err_count, mismatch_count}, 0);
      chk("rst_payload", {AWADDR, ARADDR, WSTRB, AWPROT, ARPROT}, 0);
      chk("rst_wdata", WDATA, 0);
      #2 reset = 0;

      // write-only, always-ready slave, with an ignored start while busy
      run_sweep(2'd0, 32'h0000_0100, 16'd0, 16'd0, 1'b1);
      // write/read/compare with a pattern that wraps past 2^32
      run_sweep(2'd2, 32'hFFFF_FFFE, 16'd0, 16'd0, 1'b0);
      // slave corrupts word 3 on read
      corrupt_word = 3;
      run_sweep(2'd2, 32'h0000_5A00, 16'd0, 16'd1, 1'b0);
      corrupt_word = -1;
      // WREADY ahead of AWREADY, then the reverse, then the same cycle
      aw_delay = 2; w_delay = 0;
      run_sweep(2'd2, 32'h0000_1000, 16'd0, 16'd0, 1'b0);
      aw_delay = 0; w_delay = 2;
      run_sweep(2'd2, 32'h0000_2000, 16'd0, 16'd0, 1'b0);
      aw_delay = 1; w_delay = 1; ar_delay = 1;
      run_sweep(2'd2, 32'h0000_3000, 16'd0, 16'd0, 1'b0);
      aw_delay = 0; w_delay = 0; ar_delay = 0;
      // every B and R is SLVERR; garbage read data must not count as mismatches
      err_b = 1; err_r = 1;
      run_sweep(2'd2, 32'h0000_0077, 16'd16, 16'd0, 1'b0);
      err_b = 0; err_r = 0;
      // mode 3 behaves as mode 2
      corrupt_word = 5;
      run_sweep(2'd3, 32'h0000_4000, 16'd0, 16'd1, 1'b0);
      // read-only never compares data
      corrupt_word = 2;
      run_sweep(2'd1, 32'h0000_0000, 16'd0, 16'd0, 1'b0);
      corrupt_word = -1;

      // asynchronous reset while ARVALID waits on a stalled ARREADY
      ar_delay = 1000;
      issue_start(2'd1, 32'h0);
      repeat (3) @(negedge ACLK);
      chk("ar_stalled", {ARVALID, ARREADY}, 2'b10);
      #2 reset = 1;
      #1;
      chk("async_rst_ctrl", {AWVALID, WVALID, ARVALID, BREADY, RREADY, busy, done}, 0);
      @(negedge ACLK);
      #2 reset = 0;
      ar_delay = 0;
      exp_wr.delete(); exp_rd.delete(); exp_done.delete();
      run_sweep(2'd0, 32'h0000_0300, 16'd0, 16'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
